// File: rtl/mux_nway_scan.sv
`default_nettype none
// ============================================================================
// Module      : mux_nway_scan
// Description : WAYS-to-1, WIDTH-bit multiplexer with a registered,
//               valid/ready-handshaked output. Direct mode forwards the
//               channel picked by sel; scan mode walks channels 0..WAYS-1
//               once per start request, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_nway_scan #(
    parameter int WIDTH = 1,
    parameter int WAYS  = 8,
    parameter int SEL_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WAYS*WIDTH-1:0] in_flat,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  mode,
    input  logic                  start,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  sel_err,
    output logic                  busy,
    output logic                  done
);

    localparam logic [SEL_W-1:0] c_LAST_IDX = SEL_W'(WAYS - 1);
    localparam logic [SEL_W:0]   c_WAYS     = (SEL_W + 1)'(WAYS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [SEL_W-1:0] r_cnt;
    logic             r_scan_fin;   // last scan beat already loaded
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_sel;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_sel_err;

    logic             w_load;
    logic             w_accept;
    logic             w_start_scan;
    logic             w_load_direct;
    logic             w_load_scan;
    logic             w_end_scan;
    logic [SEL_W-1:0] w_idx;
    logic [WIDTH-1:0] w_mux;
    logic             w_sel_ok;

    // Output register may take a new beat when empty or being drained.
    assign w_load   = !r_out_valid || out_ready;
    assign w_accept = r_out_valid && out_ready;

    // The scan counter drives the mux while scanning; sel otherwise.
    assign w_idx    = (r_state == S_SCAN) ? r_cnt : sel;
    assign w_sel_ok = ({1'b0, sel} < c_WAYS);

    // Channel selection; indices outside 0..WAYS-1 read as zero.
    always_comb begin
        w_mux = '0;
        for (int k = 0; k < WAYS; k++) begin
            if (w_idx == SEL_W'(k)) begin
                w_mux = in_flat[k*WIDTH +: WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-cycle datapath decisions.
    always_comb begin
        w_next_state  = r_state;
        w_start_scan  = 1'b0;
        w_load_direct = 1'b0;
        w_load_scan   = 1'b0;
        w_end_scan    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && mode) begin
                    w_next_state = S_SCAN;
                    w_start_scan = 1'b1;
                end else if (!mode && w_load) begin
                    w_load_direct = 1'b1;
                end
            end
            S_SCAN: begin
                if (w_accept && r_out_last) begin
                    w_end_scan   = 1'b1;
                    w_next_state = S_DONE;
                end else if (w_load && !r_scan_fin) begin
                    w_load_scan = 1'b1;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output register and scan counter; a stalled beat holds every field.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_scan_fin  <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_sel_err   <= 1'b0;
        end else if (w_start_scan) begin
            // No beat is loaded on the start cycle; a pending one may drain.
            r_cnt      <= '0;
            r_scan_fin <= 1'b0;
            if (w_accept) begin
                r_out_valid <= 1'b0;
            end
        end else if (w_load_direct) begin
            r_out_data  <= w_sel_ok ? w_mux : '0;
            r_out_sel   <= sel;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_sel_err   <= !w_sel_ok;
        end else if (w_load_scan) begin
            r_out_data  <= w_mux;
            r_out_sel   <= r_cnt;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_cnt == c_LAST_IDX);
            r_sel_err   <= 1'b0;
            // Stop counting at the last index so the counter never wraps.
            if (r_cnt == c_LAST_IDX) begin
                r_scan_fin <= 1'b1;
            end else begin
                r_cnt <= r_cnt + SEL_W'(1);
            end
        end else if (w_end_scan) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign sel_err   = r_sel_err;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mux_nway_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mux_nway_scan
// Description : Self-checking bench for mux_nway_scan. Two instances share
//               the control inputs: an 8-way and a 6-way (non-power-of-two)
//               variant, both 4 bits wide.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_nway_scan;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic [2:0]  sel       = 3'd0;
    logic        mode      = 1'b0;
    logic        start     = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in8       = '0;
    logic [23:0] in6       = '0;
    logic        use6      = 1'b0;

    logic [3:0] d8_data, d6_data;
    logic [2:0] d8_sel, d6_sel;
    logic       d8_valid, d8_last, d8_err, d8_busy, d8_done;
    logic       d6_valid, d6_last, d6_err, d6_busy, d6_done;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       valid;
        logic [2:0] sel;
        logic [3:0] data;
        logic       last;
        logic       err;
    } beat_t;

    beat_t sb[$];

    always #5 clk = ~clk;

    mux_nway_scan #(.WIDTH(4), .WAYS(8), .SEL_W(3)) u_dut8 (
        .clk(clk), .reset(reset), .in_flat(in8), .sel(sel), .mode(mode),
        .start(start), .out_data(d8_data), .out_sel(d8_sel),
        .out_valid(d8_valid), .out_ready(out_ready), .out_last(d8_last),
        .sel_err(d8_err), .busy(d8_busy), .done(d8_done)
    );

    mux_nway_scan #(.WIDTH(4), .WAYS(6), .SEL_W(3)) u_dut6 (
        .clk(clk), .reset(reset), .in_flat(in6), .sel(sel), .mode(mode),
        .start(start), .out_data(d6_data), .out_sel(d6_sel),
        .out_valid(d6_valid), .out_ready(out_ready), .out_last(d6_last),
        .sel_err(d6_err), .busy(d6_busy), .done(d6_done)
    );

    wire [3:0] c_data  = use6 ? d6_data  : d8_data;
    wire [2:0] c_sel   = use6 ? d6_sel   : d8_sel;
    wire       c_valid = use6 ? d6_valid : d8_valid;
    wire       c_last  = use6 ? d6_last  : d8_last;
    wire       c_err   = use6 ? d6_err   : d8_err;
    wire       c_busy  = use6 ? d6_busy  : d8_busy;
    wire       c_done  = use6 ? d6_done  : d8_done;

    function automatic beat_t obs();
        return {c_valid, c_sel, c_data, c_last, c_err};
    endfunction

    task automatic test_reset();
        #12;
        checks++;
        if ({d8_valid, d8_sel, d8_data, d8_last, d8_err, d8_busy, d8_done} !== 12'h0) begin
            errors++;
            $display("FAIL reset_dut8: got %h expected 0",
                     {d8_valid, d8_sel, d8_data, d8_last, d8_err, d8_busy, d8_done});
        end
        checks++;
        if ({d6_valid, d6_sel, d6_data, d6_last, d6_err, d6_busy, d6_done} !== 12'h0) begin
            errors++;
            $display("FAIL reset_dut6: got %h expected 0",
                     {d6_valid, d6_sel, d6_data, d6_last, d6_err, d6_busy, d6_done});
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_direct();
        beat_t exp;
        use6 = 1'b0; mode = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            for (int pass = 0; pass < 2; pass++) begin
                in8 = (pass == 0) ? 32'h0 : 32'hFFFF_FFFF;
                in8[k*4 +: 4] = (pass == 0) ? 4'h1 : 4'h0;
                sel = 3'(k);
                sb.push_back('{1'b1, 3'(k), (pass == 0) ? 4'h1 : 4'h0, 1'b0, 1'b0});
                @(posedge clk); #1;
                exp = sb.pop_front();
                checks++;
                if (obs() !== exp) begin
                    errors++;
                    $display("FAIL direct k=%0d pass=%0d: got %h expected %h", k, pass, obs(), exp);
                end
            end
        end
    endtask

    task automatic test_sel_err();
        beat_t exp;
        logic [2:0] sels [4] = '{3'd6, 3'd7, 3'd5, 3'd0};
        use6 = 1'b1; mode = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) in6[k*4 +: 4] = 4'(k + 8);
        for (int i = 0; i < 4; i++) begin
            sel = sels[i];
            if (sels[i] >= 3'd6)
                sb.push_back('{1'b1, sels[i], 4'h0, 1'b0, 1'b1});
            else
                sb.push_back('{1'b1, sels[i], 4'(sels[i] + 4'd8), 1'b0, 1'b0});
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL sel_err sel=%0d: got %h expected %h", sels[i], obs(), exp);
            end
        end
    endtask

    task automatic test_direct_stall();
        beat_t held;
        use6 = 1'b0; mode = 1'b0; out_ready = 1'b1;
        in8 = '0; in8[1*4 +: 4] = 4'hA; sel = 3'd1;
        held = '{1'b1, 3'd1, 4'hA, 1'b0, 1'b0};
        @(posedge clk); #1;
        checks++;
        if (obs() !== held) begin
            errors++;
            $display("FAIL stall_load: got %h expected %h", obs(), held);
        end
        out_ready = 1'b0; sel = 3'd2;
        in8[1*4 +: 4] = 4'h3; in8[2*4 +: 4] = 4'h5;
        start = 1'b1;                       // mode=0: must be ignored
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if (obs() !== held) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got %h expected %h", i, obs(), held);
            end
        end
        checks++;
        if (c_busy !== 1'b0) begin
            errors++;
            $display("FAIL start_mode0_ignored: busy=%b expected 0", c_busy);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs() !== beat_t'{1'b1, 3'd2, 4'h5, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stall_release: got %h expected %h", obs(),
                     beat_t'{1'b1, 3'd2, 4'h5, 1'b0, 1'b0});
        end
    endtask

    task automatic test_scan(input bit six, input bit bp, input bit restart);
        int ways;
        int cyc = 0, beats = 0, dones = 0, done_cyc = -1;
        bit held_v = 1'b0;
        beat_t held, cur, exp;
        use6 = six;
        ways = six ? 6 : 8;
        for (int k = 0; k < 8; k++) in8[k*4 +: 4] = 4'(k);
        for (int k = 0; k < 6; k++) in6[k*4 +: 4] = 4'(k ^ 10);
        sb.delete();
        for (int k = 0; k < ways; k++)
            sb.push_back('{1'b1, 3'(k), six ? 4'(k ^ 10) : 4'(k), (k == ways - 1), 1'b0});
        mode = 1'b1; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mode = 1'b0; sel = 3'd7;   // ignored while scanning
        while (dones == 0 && cyc < 60) begin
            out_ready = bp ? (cyc % 3 == 0) : 1'b1;
            if (restart && cyc == 4) begin
                start = 1'b1; mode = 1'b1;
            end else begin
                start = 1'b0; mode = 1'b0;
            end
            @(negedge clk);
            cur = obs();
            if (cyc == 1) begin
                checks++;
                if (c_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL scan_busy: busy=%b expected 1", c_busy);
                end
            end
            if (c_valid && !out_ready) begin
                if (held_v) begin
                    checks++;
                    if (cur !== held) begin
                        errors++;
                        $display("FAIL scan_stall cyc=%0d: got %h expected %h", cyc, cur, held);
                    end
                end
                held = cur; held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            if (c_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scan_extra_beat: got %h expected none", cur);
                end else begin
                    exp = sb.pop_front();
                    if (cur !== exp) begin
                        errors++;
                        $display("FAIL scan_beat %0d: got %h expected %h", beats, cur, exp);
                    end
                end
                beats++;
            end
            if (c_done) begin
                dones++; done_cyc = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; mode = 1'b0;
        checks++;
        if (dones != 1 || beats != ways || sb.size() != 0) begin
            errors++;
            $display("FAIL scan_count: dones=%0d beats=%0d left=%0d expected 1/%0d/0",
                     dones, beats, sb.size(), ways);
        end
        if (!bp) begin
            checks++;
            if (done_cyc != ways + 1) begin
                errors++;
                $display("FAIL scan_throughput: done at cycle %0d expected %0d", done_cyc, ways + 1);
            end
        end
        @(negedge clk);
        checks++;
        if ({c_busy, c_done, c_valid} !== 3'b000) begin
            errors++;
            $display("FAIL scan_after: busy/done/valid=%b expected 000", {c_busy, c_done, c_valid});
        end
    endtask

    task automatic test_reset_mid_scan();
        bit seen = 1'b0;
        bit quiet = 1'b1;
        use6 = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) in8[k*4 +: 4] = 4'(k);
        mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (c_valid && c_sel == 3'd3) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_mid_scan_reach: sel 3 not seen, expected within 20 cycles");
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({d8_valid, d8_sel, d8_data, d8_last, d8_err, d8_busy, d8_done} !== 12'h0) begin
            errors++;
            $display("FAIL reset_async: got %h expected 0",
                     {d8_valid, d8_sel, d8_data, d8_last, d8_err, d8_busy, d8_done});
        end
        @(posedge clk); #2;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (c_done || c_busy || c_valid) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL reset_no_done: activity after reset, expected none");
        end
        @(posedge clk); #1;
        mode = 1'b0; sel = 3'd4;
        @(posedge clk); #1;
        checks++;
        if (obs() !== beat_t'{1'b1, 3'd4, 4'h4, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_then_direct: got %h expected %h", obs(),
                     beat_t'{1'b1, 3'd4, 4'h4, 1'b0, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_sel_err();
        test_direct_stall();
        test_scan(1'b0, 1'b0, 1'b0);
        test_scan(1'b0, 1'b1, 1'b1);
        test_reset_mid_scan();
        test_scan(1'b1, 1'b0, 1'b0);
        test_scan(1'b1, 1'b1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
